// File: rtl/irq_controller_pkg.sv
// Shared types and constants for the machine-level external interrupt controller.
package irq_pkg;

  localparam int N_IRQ_MAX  = 16;
  localparam int CAUSE_BASE = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRAP    = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // Interrupt causes carry the MSB set; line i reports base + i.
  function automatic logic [31:0] make_mcause(input logic [3:0] idx,
                                              input int unsigned base = CAUSE_BASE);
    logic [31:0] code;
    code = base + 32'(idx);
    return {1'b1, code[30:0]};
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Request/CSR/trap signals between the platform, the core and the interrupt controller.
interface irq_controller_if
  import irq_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_MAX
);

  logic [N_IRQ-1:0] irq_req;
  logic [31:0]      mie;
  logic             mret;
  logic             irq;
  logic [31:0]      mcause;
  logic [N_IRQ-1:0] irq_ret;

  modport master (
    output irq_req, mie, mret,
    input  irq, mcause, irq_ret
  );

  modport slave (
    input  irq_req, mie, mret,
    output irq, mcause, irq_ret
  );

endinterface

// File: rtl/irq_controller_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational, no backpressure.
module irq_prio_enc #(
  parameter int N_IRQ = 16
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [3:0]       idx
);

  // Scan downward so the last hit, and therefore the winner, is the lowest index.
  always_comb begin
    valid = 1'b0;
    idx   = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-latched external interrupt controller: trap two cycles after an edge, ack on mret.
// irq/irq_ret are registered pulses; further traps are held off until mret returns to IDLE.
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ      = 16,
  parameter int CAUSE_BASE = 16
) (
  input logic             clock,
  input logic             reset_n,
  irq_controller_if.slave bus
);

  localparam logic [N_IRQ-1:0] ONE = N_IRQ'(1);

  irq_state_t       state;
  logic [N_IRQ-1:0] req_q;
  logic [N_IRQ-1:0] pend;
  logic [3:0]       idx;
  logic             irq_q;
  logic [N_IRQ-1:0] irq_ret_q;
  logic [31:0]      mcause_q;

  logic [N_IRQ-1:0] edges;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] clr_mask;
  logic             sel_vld;
  logic [3:0]       sel_idx;
  logic             take;
  logic             unused_mie;

  assign edges = bus.irq_req & ~req_q;
  assign elig  = pend & bus.mie[CAUSE_BASE +: N_IRQ];
  assign unused_mie = ^bus.mie;

  irq_prio_enc #(
    .N_IRQ(N_IRQ)
  ) u_prio (
    .req  (elig),
    .valid(sel_vld),
    .idx  (sel_idx)
  );

  assign take     = (state == IDLE) && sel_vld;
  assign clr_mask = take ? (ONE << sel_idx) : '0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_q     <= '0;
      pend      <= '0;
      idx       <= 4'd0;
      irq_q     <= 1'b0;
      irq_ret_q <= '0;
      mcause_q  <= 32'h0;
    end else begin
      req_q     <= bus.irq_req;
      // A fresh edge on the line being taken re-pends it: set wins over clear.
      pend      <= (pend & ~clr_mask) | edges;
      irq_q     <= 1'b0;
      irq_ret_q <= '0;
      case (state)
        IDLE: begin
          if (take) begin
            state    <= TRAP;
            idx      <= sel_idx;
            mcause_q <= make_mcause(sel_idx, CAUSE_BASE);
            irq_q    <= 1'b1;
          end
        end
        TRAP: begin
          state <= SERVICE;
        end
        SERVICE: begin
          if (bus.mret) begin
            state     <= IDLE;
            irq_ret_q <= ONE << idx;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.irq     = irq_q;
  assign bus.irq_ret = irq_ret_q;
  assign bus.mcause  = mcause_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; inputs change and outputs are sampled 1ns after each rising edge.
module tb_irq_controller;

  logic clock;
  logic reset_n;
  int   total;
  int   passed;
  int   fails;
  int   irq_count;

  irq_controller_if #(.N_IRQ(16)) bus ();

  irq_controller #(
    .N_IRQ     (16),
    .CAUSE_BASE(16)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0; passed = 0; fails = 0; irq_count = 0;
    reset_n = 1'b0;
    bus.irq_req = 16'h0;
    bus.mie = 32'h0;
    bus.mret = 1'b0;
    repeat (3) tick();
    chk("rst_irq", 32'(bus.irq), 32'h0);
    chk("rst_irq_ret", 32'(bus.irq_ret), 32'h0);
    chk("rst_mcause", bus.mcause, 32'h0);
    chk("rst_pend", 32'(dut.pend), 32'h0);
    reset_n = 1'b1;
    tick();

    // Line 3, enabled by mie bit 19
    bus.mie = 32'h0008_0000;
    bus.irq_req = 16'h0008;
    tick();
    chk("t1_irq_n1", 32'(bus.irq), 32'h0);
    tick();
    chk("t1_irq_n2", 32'(bus.irq), 32'h1);
    chk("t1_mcause", bus.mcause, 32'h8000_0013);
    chk("t1_pend_clr", 32'(dut.pend), 32'h0);
    bus.irq_req = 16'h0;
    tick();
    chk("t1_irq_n3", 32'(bus.irq), 32'h0);
    repeat (4) tick();
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    chk("t1_irq_ret", 32'(bus.irq_ret), 32'h0008);
    chk("t1_mcause_hold", bus.mcause, 32'h8000_0013);
    tick();
    chk("t1_irq_ret_off", 32'(bus.irq_ret), 32'h0);

    // Lines 5 and 2 together, everything enabled
    bus.mie = 32'hFFFF_FFFF;
    bus.irq_req = 16'h0024;
    tick();
    bus.irq_req = 16'h0;
    tick();
    chk("t2_irq_a", 32'(bus.irq), 32'h1);
    chk("t2_mcause_a", bus.mcause, 32'h8000_0012);
    tick();
    chk("t2_pend", 32'(dut.pend), 32'h0020);
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    chk("t2_irq_ret_a", 32'(bus.irq_ret), 32'h0004);
    chk("t2_irq_m1", 32'(bus.irq), 32'h0);
    tick();
    chk("t2_irq_b", 32'(bus.irq), 32'h1);
    chk("t2_mcause_b", bus.mcause, 32'h8000_0015);
    tick();
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    chk("t2_irq_ret_b", 32'(bus.irq_ret), 32'h0020);
    tick();

    // Line 7 masked, then enabled via mie bit 23
    bus.mie = 32'h0;
    bus.irq_req = 16'h0080;
    tick();
    bus.irq_req = 16'h0;
    tick();
    tick();
    chk("t3_irq_masked", 32'(bus.irq), 32'h0);
    chk("t3_pend_held", 32'(dut.pend), 32'h0080);
    bus.mie = 32'h0080_0000;
    tick();
    chk("t3_irq", 32'(bus.irq), 32'h1);
    chk("t3_mcause", bus.mcause, 32'h8000_0017);
    tick();
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    chk("t3_irq_ret", 32'(bus.irq_ret), 32'h0080);
    tick();

    // Line 1 re-pended during its own service
    bus.mie = 32'hFFFF_FFFF;
    bus.irq_req = 16'h0002;
    tick();
    bus.irq_req = 16'h0;
    tick();
    chk("t4_irq_a", 32'(bus.irq), 32'h1);
    chk("t4_mcause_a", bus.mcause, 32'h8000_0011);
    tick();
    bus.irq_req = 16'h0002;
    tick();
    bus.irq_req = 16'h0;
    chk("t4_repend", 32'(dut.pend), 32'h0002);
    chk("t4_no_nest", 32'(bus.irq), 32'h0);
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    chk("t4_irq_ret_a", 32'(bus.irq_ret), 32'h0002);
    tick();
    chk("t4_irq_b", 32'(bus.irq), 32'h1);
    chk("t4_mcause_b", bus.mcause, 32'h8000_0011);
    tick();
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    chk("t4_irq_ret_b", 32'(bus.irq_ret), 32'h0002);
    tick();
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    chk("t4_stray_mret", 32'(bus.irq_ret), 32'h0);
    tick();
    chk("t4_stray_irq", 32'(bus.irq), 32'h0);

    // Reset during service of line 4, line held high across release
    bus.irq_req = 16'h0010;
    tick();
    tick();
    chk("t5_irq", 32'(bus.irq), 32'h1);
    chk("t5_mcause", bus.mcause, 32'h8000_0014);
    tick();
    reset_n = 1'b0;
    tick();
    chk("t5_rst_irq", 32'(bus.irq), 32'h0);
    chk("t5_rst_irq_ret", 32'(bus.irq_ret), 32'h0);
    chk("t5_rst_mcause", bus.mcause, 32'h0);
    chk("t5_rst_pend", 32'(dut.pend), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t5_rel_pend", 32'(dut.pend), 32'h0010);
    chk("t5_rel_irq", 32'(bus.irq), 32'h0);
    tick();
    chk("t5_retrap", 32'(bus.irq), 32'h1);
    chk("t5_retrap_mcause", bus.mcause, 32'h8000_0014);
    tick();
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    chk("t5_irq_ret", 32'(bus.irq_ret), 32'h0010);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.irq === 1'b1) irq_count++;
    end
    chk("t5_single_trap", 32'(irq_count), 32'h0);
    bus.irq_req = 16'h0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Machine-level external interrupt controller for the single-cycle RISC-V core. It detects rising edges on up to 16 platform interrupt lines and latches them as pending. It masks them with the `mie` value from the CSR file, selects the highest-priority pending line, and raises a one-cycle trap request with a matching `mcause`. It then holds off further traps until the handler executes `mret`, and acknowledges the serviced line at that point. It is the producer of the `mcause` consumed by the CSR file and the consumer of that block's `mie` output.

## Interface
- `N_IRQ`, 16, number of interrupt lines (1..16)
- `CAUSE_BASE`, 16, exception code of line 0; line i reports code `CAUSE_BASE + i`

- `clock`, in, 1, core clock; all state updates on the rising edge
- `reset_n`, in, 1, reset, synchronous and active-low
- `irq_req`, in, N_IRQ, interrupt request lines from peripherals, synchronous to `clock`
- `mie`, in, 32, CSR `mie`; bit `CAUSE_BASE+i` enables line i; other bits ignored
- `mret`, in, 1, decoder flag: an `mret` instruction executes this cycle
- `irq`, out, 1, trap request, one-cycle pulse; the core asserts CSROp[2] and loads PC from `mtvec`
- `mcause`, out, 32, cause of the current or most recent trap
- `irq_ret`, out, N_IRQ, one-hot acknowledge pulse to the serviced peripheral on `mret`

## Operation
- Edge detect: register `req_q` holds the previous `irq_req`. An edge on line i is `irq_req[i] & ~req_q[i]`.
- Pending: register `pend[N_IRQ-1:0]`.
  - An edge on line i sets `pend[i]`.
  - Entering TRAP clears the selected bit.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Eligible lines: `pend & mie[CAUSE_BASE +: N_IRQ]`. Lowest index has highest priority.
- State machine with three states:
  - IDLE: if any line is eligible, go to TRAP. Latch `idx` = selected line and `mcause = {1'b1, 31'(CAUSE_BASE + idx)}`. Clear `pend[idx]`.
  - TRAP: `irq` = 1 for exactly this cycle. Always go to SERVICE next.
  - SERVICE: wait for `mret`. On `mret`, pulse `irq_ret[idx]` for one cycle and go to IDLE.
- `mret` in IDLE or TRAP is ignored; no `irq_ret` pulse is produced.
- Changes to `mie` while in TRAP or SERVICE do not affect the trap in progress.
- A masked pending line stays pending. It is taken once its enable bit is set while the controller is in IDLE.
- There is no nesting. Edges arriving during TRAP or SERVICE, including on the line being serviced, are recorded in `pend` and taken after return.
- Multiple edges on one line before it is taken collapse into a single pending event.

## Timing
- Reset, applied while `reset_n` is sampled low on a clock edge:
  - State returns to IDLE.
  - `pend`, `req_q`, `idx` = 0; `irq` = 0; `irq_ret` = 0; `mcause` = 32'h0.
  - Reset asserted mid-trap or mid-service abandons the trap; no `irq_ret` is issued.
- A line held high through reset release registers exactly one edge on the first cycle after release.
- Latencies:
  - Edge on `irq_req` at cycle n sets `pend` at edge n+1.
  - If eligible and in IDLE, the controller enters TRAP at edge n+2, so `irq` is high during cycle n+2.
  - `mcause` is valid from the cycle `irq` rises and is held until the next trap.
  - `mret` sampled at cycle m produces `irq_ret` high during cycle m+1, with state IDLE.
  - The earliest next `irq` is cycle m+2.
- `irq` and `irq_ret` are registered outputs with no combinational path from any input.

## Structure
- Package `irq_pkg`:
  - `N_IRQ_MAX` = 16 and `CAUSE_BASE` = 16
  - state enum `irq_state_t` {IDLE, TRAP, SERVICE}
  - function `make_mcause(idx)`
- Sub-module `irq_prio_enc`: combinational lowest-index-first priority encoder. Outputs `valid` and `idx[3:0]`, parameterised on `N_IRQ`.
- Top level instantiates `irq_prio_enc` once. Edge detect, pending register, FSM and output registers are in the top level.

## Test plan
- Edge on line 3 only, with `mie` = 32'h0008_0000 (bit 19):
  - `irq` pulses exactly 2 cycles after the edge, with `mcause` = 32'h8000_0013.
  - `mret` 5 cycles later gives `irq_ret` = 16'h0008 for one cycle.
- Simultaneous edges on lines 5 and 2, all enabled:
  - First trap has `mcause` = 32'h8000_0012.
  - After `mret`, the second trap has `mcause` = 32'h8000_0015, no earlier than 2 cycles after the `mret` cycle.
- Line 7 edge with `mie` = 0:
  - No `irq` is raised and `pend[7]` stays set.
  - Writing `mie` bit 23 yields `irq` 1 cycle later with `mcause` = 32'h8000_0017.
- During SERVICE of line 1:
  - A new edge on line 1 re-pends it.
  - `mret` gives `irq_ret` = 16'h0002, then a second trap with `mcause` = 32'h8000_0011.
  - A stray `mret` in IDLE produces no `irq_ret`.
- Reset asserted in SERVICE:
  - The next cycle shows `irq` = 0, `irq_ret` = 0, `mcause` = 0 and `pend` = 0.
  - A line held high across release traps exactly once.
